uart_burst_tx: RTL

UART_BURST_TX -- requirements
Module: uart_burst_tx

---
 rtl/uart_burst_tx_pkg.sv | 21 ++
 rtl/uart_burst_tx_bit_timer.sv | 36 +++
 rtl/uart_burst_tx.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_burst_tx_pkg.sv
// rtl/uart_burst_tx_pkg.sv - shared constants and state encoding for the burst UART transmitter
//
// Holds the FSM state type, the default bit period and stop-bit count,
// the maximum burst length and the frame (data byte) width.

package uart_burst_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_STOP_BITS    = 1;
  localparam int MAX_BYTES        = 15;
  localparam int FRAME_W          = 8;
  localparam int DATA_W           = MAX_BYTES * FRAME_W;

endpackage

// File: rtl/uart_burst_tx_bit_timer.sv
// rtl/uart_burst_tx_bit_timer.sv - bit-period counter for the burst UART transmitter
//
// Ports:
//   clk     clock
//   rst     synchronous active-high reset
//   enable  count while high; counter is held at 0 while low
//   tick    high for one cycle while the count sits at CLKS_PER_BIT-1

module tx_bit_timer
  import uart_burst_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  logic [7:0] cnt;

  // Combinational decode of a registered count; tick marks the last cycle
  // of the current bit so the FSM advances on the edge that ends it.
  assign tick = enable && (cnt == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/uart_burst_tx.sv
// rtl/uart_burst_tx.sv - multi-byte UART transmitter, highest byte index first
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   start    burst request, honoured only in IDLE and not in the done cycle
//   n_bytes  burst length 1..15, sampled with start (0 is ignored)
//   data_in  payload, byte k at data_in[8k+7:8k]
//   bit_out  registered serial line, idle high
//   busy     high while a burst is in progress
//   done     one-cycle pulse after the last stop bit

module uart_burst_tx
  import uart_burst_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        n_bytes,
  input  logic [DATA_W-1:0] data_in,
  output logic              bit_out,
  output logic              busy,
  output logic              done
);

  tx_state_t         state, state_n;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        byte_idx, byte_idx_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic              stop_idx, stop_idx_n;
  logic              tick;
  logic              accept;
  logic              last_stop;
  logic              line_d, busy_d, done_d;
  logic [FRAME_W-1:0] cur_byte;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(state != IDLE),
    .tick  (tick)
  );

  // done is high only in the first IDLE cycle, so gating on it rejects a
  // start presented in the completion cycle.
  assign accept    = start && (n_bytes != 4'd0) && !done;
  assign cur_byte  = data_q[{byte_idx, 3'b000} +: FRAME_W];
  assign last_stop = tick && (stop_idx == 1'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = START;
      START: if (tick) state_n = DATA;
      DATA:  if (tick && (bit_idx == 3'd7)) state_n = STOP;
      STOP:  if (last_stop) state_n = (byte_idx == 4'd0) ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end

  // Next counter values and the next-cycle line/flag values; all of them
  // are registered below so the outputs never see combinational glitches.
  always_comb begin
    byte_idx_n = byte_idx;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    if (state == IDLE && accept) byte_idx_n = n_bytes - 4'd1;
    // 7 -> 0 here coincides with leaving DATA, so no wrap inside a frame.
    if (state == DATA && tick) bit_idx_n = bit_idx + 3'd1;
    if (state == STOP && tick) stop_idx_n = last_stop ? 1'b0 : ~stop_idx;
    if (state == STOP && last_stop && byte_idx != 4'd0) byte_idx_n = byte_idx - 4'd1;

    case (state_n)
      START:   line_d = 1'b0;
      DATA:    line_d = cur_byte[bit_idx_n];
      default: line_d = 1'b1;
    endcase
    busy_d = (state_n != IDLE);
    done_d = (state == STOP) && (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      bit_out  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (state == IDLE && accept) data_q <= data_in;
      byte_idx <= byte_idx_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      bit_out  <= line_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
